id_ex_pipe: RTL and testbench

ID/EX pipeline register of the 5-stage MIPS core with integrated load-use hazard detection. Captures the decoded instruction from ID each cycle and presents registered control, operands and register specifiers to EX, the forwarding unit and the ALU. It resolves load-use hazards on its own: it inserts a bubble and asserts a stall to PC and IF/ID. It also honours branch flush and a global memory stall.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/load_use_detect.sv | 16 +
 rtl/id_ex_pipe.sv | 85 ++++++++
 tb/tb_id_ex_pipe.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bundle types and constants for the MIPS pipeline registers.
package pipe_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [7:0] CTRL_BUBBLE = 8'h00;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [4:0] REG_ZERO    = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       flush_i,
    output logic       hazard_o,
    output logic       stall_o
);
    assign hazard_o = ex_memread_i && (ex_rt_i != REG_ZERO) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
    // A squashed ID instruction never needs to wait for the load.
    assign stall_o  = hazard_o && !flush_i;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, flush and memory freeze.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    input  logic [7:0]        ctrl_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    output logic [7:0]        ctrl_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard, stall;

    load_use_detect u_lud (
        .ex_memread_i (ctrl_q.mem_read),
        .ex_rt_i      (rt_q),
        .id_rs_i      (rs_i),
        .id_rt_i      (rt_i),
        .flush_i      (flush_i),
        .hazard_o     (hazard),
        .stall_o      (stall)
    );

    // Hazard bubbles also zero the specifiers so forwarding cannot match them.
    always_comb begin
        ctrl_d = (flush_i || hazard) ? ctrl_t'(CTRL_BUBBLE) : ctrl_t'(ctrl_i);
        rs_d   = stall ? REG_ZERO : rs_i;
        rt_d   = stall ? REG_ZERO : rt_i;
        rd_d   = stall ? REG_ZERO : rd_i;
        cnt_d  = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q    <= ctrl_t'(CTRL_BUBBLE);
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= REG_ZERO;
            rt_q      <= REG_ZERO;
            rd_q      <= REG_ZERO;
            cnt_q     <= '0;
        end else if (!mem_stall_i) begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_i;
            rt_data_q <= rt_data_i;
            imm_q     <= imm_i;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ctrl_o      = ctrl_q;
    assign rs_data_o   = rs_data_q;
    assign rt_data_o   = rt_data_q;
    assign imm_o       = imm_q;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: vector table with a scoreboard queue, plus reset and saturation sequences.
module tb_id_ex_pipe;
    localparam logic [7:0] LW  = 8'hE8;
    localparam logic [7:0] ADD = 8'h86;
    localparam logic [7:0] SW  = 8'h18;

    logic        clk_i = 0, rst_i = 1, mem_stall_i = 0, flush_i = 0;
    logic [7:0]  ctrl_i = 0, ctrl_o;
    logic [31:0] rs_data_i = 0, rt_data_i = 0, imm_i = 0, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_i = 0, rt_i = 0, rd_i = 0, rs_o, rt_o, rd_o;
    logic        stall_o;
    logic [1:0]  stall_cnt_o;
    int checks = 0, errors = 0;

    id_ex_pipe #(.DATA_W(32), .CNT_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .ctrl_i(ctrl_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .ctrl_o(ctrl_o), .rs_data_o(rs_data_o),
        .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic ms, fl; logic [7:0] ctrl; logic [4:0] rs, rt, rd; logic [31:0] data;
        logic e_stall; logic [7:0] e_ctrl; logic [4:0] e_rs, e_rt, e_rd; logic [31:0] e_data; logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[20];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ms, input logic fl, input logic [7:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d);
        mem_stall_i = ms; flush_i = fl; ctrl_i = c; rs_i = rs; rt_i = rt; rd_i = rd;
        rs_data_i = d; rt_data_i = ~d; imm_i = d ^ 32'h55;
    endtask

    initial begin
        vec_t e;
        int   sat_exp[5];
        vecs = '{
            '{0,0,LW ,1,8,0 ,32'h100, 0,LW ,1,8,0 ,32'h100,0},
            '{0,0,ADD,8,2,9 ,32'h200, 1,8'h0,0,0,0,32'h200,1},
            '{0,0,ADD,8,2,9 ,32'h200, 0,ADD,8,2,9 ,32'h200,1},
            '{0,0,LW ,1,0,0 ,32'h300, 0,LW ,1,0,0 ,32'h300,1},
            '{0,0,ADD,0,0,10,32'h301, 0,ADD,0,0,10,32'h301,1},
            '{0,0,LW ,1,8,0 ,32'h400, 0,LW ,1,8,0 ,32'h400,1},
            '{0,0,ADD,3,4,5 ,32'h401, 0,ADD,3,4,5 ,32'h401,1},
            '{0,0,ADD,2,8,6 ,32'h402, 0,ADD,2,8,6 ,32'h402,1},
            '{0,0,LW ,1,7,0 ,32'h500, 0,LW ,1,7,0 ,32'h500,1},
            '{0,1,ADD,7,1,2 ,32'h501, 0,8'h0,7,1,2 ,32'h501,1},
            '{0,0,LW ,1,6,0 ,32'h600, 0,LW ,1,6,0 ,32'h600,1},
            '{1,0,ADD,6,6,3 ,32'h601, 1,LW ,1,6,0 ,32'h600,1},
            '{1,0,SW ,2,6,0 ,32'h602, 1,LW ,1,6,0 ,32'h600,1},
            '{1,1,ADD,4,5,7 ,32'h603, 0,LW ,1,6,0 ,32'h600,1},
            '{0,0,ADD,6,9,3 ,32'h604, 1,8'h0,0,0,0,32'h604,2},
            '{0,0,ADD,6,9,3 ,32'h604, 0,ADD,6,9,3 ,32'h604,2},
            '{0,0,LW ,1,8,0 ,32'h700, 0,LW ,1,8,0 ,32'h700,2},
            '{0,0,ADD,8,8,11,32'h701, 1,8'h0,0,0,0,32'h701,3},
            '{0,0,LW ,1,8,0 ,32'h702, 0,LW ,1,8,0 ,32'h702,3},
            '{0,0,ADD,2,8,12,32'h703, 1,8'h0,0,0,0,32'h703,3}
        };
        sat_exp = '{1, 2, 3, 3, 3};
        repeat (2) @(negedge clk_i);
        chk("reset_ctrl", ctrl_o, 0);
        chk("reset_cnt", stall_cnt_o, 0);
        chk("reset_stall", stall_o, 0);
        rst_i = 0;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].ms, vecs[i].fl, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].data);
            #1 chk($sformatf("v%0d_stall", i), stall_o, vecs[i].e_stall);
            sb.push_back(vecs[i]);
            @(posedge clk_i);
            #1 e = sb.pop_front();
            chk($sformatf("v%0d_ctrl", i), ctrl_o, e.e_ctrl);
            chk($sformatf("v%0d_rs", i), rs_o, e.e_rs);
            chk($sformatf("v%0d_rt", i), rt_o, e.e_rt);
            chk($sformatf("v%0d_rd", i), rd_o, e.e_rd);
            chk($sformatf("v%0d_rsdata", i), rs_data_o, e.e_data);
            chk($sformatf("v%0d_rtdata", i), rt_data_o, ~e.e_data);
            chk($sformatf("v%0d_imm", i), imm_o, e.e_data ^ 32'h55);
            chk($sformatf("v%0d_cnt", i), stall_cnt_o, e.e_cnt);
        end

        @(negedge clk_i);
        drive(0, 0, LW, 1, 8, 0, 32'h800);
        @(posedge clk_i);
        #2 rst_i = 1;
        #1;
        chk("async_rst_ctrl", ctrl_o, 0);
        chk("async_rst_rsdata", rs_data_o, 0);
        chk("async_rst_imm", imm_o, 0);
        chk("async_rst_rt", rt_o, 0);
        chk("async_rst_cnt", stall_cnt_o, 0);
        rst_i = 0;

        for (int p = 0; p < 5; p++) begin
            @(negedge clk_i);
            drive(0, 0, LW, 1, 8, 0, 32'h900);
            @(negedge clk_i);
            drive(0, 0, ADD, 8, 3, 4, 32'h901);
            #1 chk($sformatf("sat%0d_stall", p), stall_o, 1);
            @(posedge clk_i);
            #1 chk($sformatf("sat%0d_cnt", p), stall_cnt_o, sat_exp[p]);
        end

        @(negedge clk_i);
        drive(0, 0, LW, 1, 8, 0, 32'hA00);
        @(negedge clk_i);
        drive(0, 0, ADD, 8, 3, 4, 32'hA01);
        #1 chk("midstall_stall", stall_o, 1);
        rst_i = 1;
        #1 chk("midstall_rst_stall", stall_o, 0);
        chk("midstall_rst_cnt", stall_cnt_o, 0);
        rst_i = 0;
        @(posedge clk_i);
        #1 chk("midstall_reload_ctrl", ctrl_o, ADD);
        chk("midstall_reload_rs", rs_o, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
